// File: rtl/delay_timer_pkg.sv
// delay_timer shared types and default constants.
// Used by delay_timer and start_edge_detect.
package delay_timer_pkg;

  localparam int DT_CNT_W        = 16;
  localparam int DT_DELAY_CYCLES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } dt_state_e;

endpackage

// File: rtl/start_edge_detect.sv
// Registers start and flags its rising edge.
// start_q resets low, so a start held through reset reads as an edge.
module start_edge_detect
  import delay_timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic rise
);

  logic start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  assign rise = start & ~start_q;

endmodule

// File: rtl/delay_timer.sv
// Single-shot delay timer: start edge -> DELAY_CYCLES -> one-cycle done.
// Define DELAY_TIMER_RETRIGGER_EN to let edges during COUNT reload the delay.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int DELAY_CYCLES = DT_DELAY_CYCLES,
  parameter int CNT_W        = DT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam longint unsigned MAX_DELAY =
    (64'd1 << CNT_W) - 64'd1;

  if (DELAY_CYCLES < 1 ||
      64'(DELAY_CYCLES) > MAX_DELAY) begin : g_bad_delay
    $error("delay_timer: DELAY_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             rise;
  logic             reload;
  dt_state_e        state_q;
  dt_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;
  logic             busy_q;
  logic             busy_d;

  start_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rise  (rise)
  );

`ifdef DELAY_TIMER_RETRIGGER_EN
  assign reload = rise;
`else
  assign reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = COUNT;
          cnt_d   = LOAD;
        end
      end
      COUNT: begin
        if (reload) begin
          cnt_d = LOAD;
        end else if (cnt_q <= ONE) begin
          // <= rather than == keeps the count from ever wrapping
          state_d = FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      FIRE: begin
        if (rise) begin
          state_d = COUNT;
          cnt_d   = LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    done_d = (state_d == FIRE);
    busy_d = (state_d == COUNT);
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = cnt_q;

endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer: D=5 and D=1 instances.
// Expected done cycles are queued when edges are driven.
module tb_delay_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start5;
  logic        start1;
  logic        done5;
  logic        busy5;
  logic [15:0] rem5;
  logic        done1;
  logic        busy1;
  logic [15:0] rem1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int q5[$];
  int q1[$];
  int k;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  delay_timer #(.DELAY_CYCLES(5), .CNT_W(16)) u5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start5),
    .done      (done5),
    .busy      (busy5),
    .remaining (rem5)
  );

  delay_timer #(.DELAY_CYCLES(1), .CNT_W(16)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .done      (done1),
    .busy      (busy1),
    .remaining (rem1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  // done monitor: each pulse must match the oldest queued cycle
  always @(negedge clk) begin
    if (done5) begin
      if (q5.size() == 0) check("done5_pending", 32'(q5.size()), 32'd1);
      else check("done5_cyc", 32'(cyc), 32'(q5.pop_front()));
    end
    if (done1) begin
      if (q1.size() == 0) check("done1_pending", 32'(q1.size()), 32'd1);
      else check("done1_cyc", 32'(cyc), 32'(q1.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    start5 = 1'b0;
    start1 = 1'b0;
    repeat (3) tick();
    check("rst_done5", 32'(done5), 32'd0);
    check("rst_busy5", 32'(busy5), 32'd0);
    check("rst_rem5",  32'(rem5),  32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_rem1",  32'(rem1),  32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // basic count, start held 10 cycles
    start5 = 1'b1;
    k = cyc + 1;
    q5.push_back(k + 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("basic_rem5",  32'(rem5),  32'(5 - i));
      check("basic_busy5", 32'(busy5), 32'(i < 5));
    end
    repeat (4) tick();
    start5 = 1'b0;
    repeat (3) tick();

    // held start for 20 cycles: a single done
    start5 = 1'b1;
    k = cyc + 1;
    q5.push_back(k + 5);
    repeat (20) tick();
    start5 = 1'b0;
    repeat (3) tick();

    // back-to-back: second edge sampled while in FIRE
    start5 = 1'b1;
    k = cyc + 1;
    q5.push_back(k + 5);
    wait_cyc(k + 4);
    start5 = 1'b0;
    wait_cyc(k + 5);
    check("b2b_fire_done", 32'(done5), 32'd1);
    check("b2b_fire_busy", 32'(busy5), 32'd0);
    start5 = 1'b1;
    q5.push_back(k + 6 + 5);
    wait_cyc(k + 6);
    check("b2b_reload_rem", 32'(rem5), 32'd5);
    wait_cyc(k + 8);
    start5 = 1'b0;
    wait_cyc(k + 14);

    // mid-count edge at relative cycles 0 and 2
    start5 = 1'b1;
    k = cyc + 1;
`ifdef DELAY_TIMER_RETRIGGER_EN
    q5.push_back(k + 7);
`else
    q5.push_back(k + 5);
`endif
    tick();
    start5 = 1'b0;
    tick();
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    check("mid_busy5", 32'(busy5), 32'd1);
    wait_cyc(k + 12);

    // DELAY_CYCLES = 1
    start1 = 1'b1;
    k = cyc + 1;
    q1.push_back(k + 1);
    tick();
    check("d1_busy_on",  32'(busy1), 32'd1);
    check("d1_rem_on",   32'(rem1),  32'd1);
    check("d1_done_off", 32'(done1), 32'd0);
    tick();
    check("d1_busy_off", 32'(busy1), 32'd0);
    check("d1_rem_off",  32'(rem1),  32'd0);
    check("d1_done_on",  32'(done1), 32'd1);
    start1 = 1'b0;
    repeat (3) tick();

    // reset mid-count aborts; start held across reset is an edge
    start5 = 1'b1;
    tick();
    tick();
    start5 = 1'b0;
    tick();
    check("abort_busy_pre", 32'(busy5), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_done5", 32'(done5), 32'd0);
    check("abort_busy5", 32'(busy5), 32'd0);
    check("abort_rem5",  32'(rem5),  32'd0);
    start1 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    k = cyc + 1;
    q1.push_back(k + 1);
    tick();
    check("rel_busy1", 32'(busy1), 32'd1);
    tick();
    start1 = 1'b0;
    repeat (12) tick();

    check("q5_drained", 32'(q5.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
